// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-memory responder: access widths, FSM states,
// wait-counter width and the access legality check.
package data_mem_responder_pkg;

   localparam logic [1:0] WIDTH_BYTE = 2'b00;
   localparam logic [1:0] WIDTH_HALF = 2'b01;
   localparam logic [1:0] WIDTH_WORD = 2'b10;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } stateT;

   // Width 11 is reserved; halves need even addresses, words need 4-byte alignment.
   function automatic logic accessLegal(input logic [1:0] width, input logic [1:0] offset);
      logic ok;
      case (width)
         WIDTH_BYTE: ok = 1'b1;
         WIDTH_HALF: ok = ~offset[0];
         WIDTH_WORD: ok = (offset == 2'b00);
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/data_mem_responder_sram.sv
// Word-organised backing store with per-byte write enables, synchronous write
// and asynchronous read. Contents are deliberately not reset.
module dmem_sram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wrData,
   output logic [31:0]   rdData
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wrData[8*i +: 8];
         end
      end
   end

   assign rdData = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory responder: accepts one load/store per request, inserts
// WAIT_CYCLES wait states, then completes with a single Done pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for a legal request; accept latches it and stalls
// ST_WAIT | wait states, counter runs down to zero, stall held
// ST_RESP | one-cycle completion: load data out, store commits at edge
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Mem_DcacheEN,
   input  logic        Mem_DcacheRd,
   input  logic [1:0]  Mem_DcacheWidth,
   input  logic        Mem_DcacheSign,
   input  logic [31:0] Mem_DcacheAddr,
   input  logic [31:0] EXMem_Rs2Data,
   output logic [31:0] Dcache_DataRd,
   output logic        Dcache_StallReq,
   output logic        Dcache_Done,
   output logic        Dcache_Misalign
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

   stateT            state;
   logic [CNT_W-1:0] cnt;
   logic             rdL;
   logic [1:0]       widthL;
   logic             signL;
   logic [AW+1:0]    addrL;
   logic [31:0]      dataL;

   logic             legal;
   logic             accept;
   logic             memWe;
   logic [3:0]       memBe;
   logic [31:0]      memWrData;
   logic [31:0]      rdWord;
   logic [31:0]      loadData;
   logic             unusedAddrHi;

   // Upper address bits only select aliases of the same word.
   assign unusedAddrHi = ^Mem_DcacheAddr[31:AW+2];

   assign legal  = accessLegal(Mem_DcacheWidth, Mem_DcacheAddr[1:0]);
   assign accept = (state == ST_IDLE) && Mem_DcacheEN && legal;

   assign Dcache_Misalign = (state == ST_IDLE) && Mem_DcacheEN && !legal;
   assign Dcache_StallReq = !rst && (accept || (state == ST_WAIT));
   assign Dcache_Done     = (state == ST_RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         rdL    <= 1'b0;
         widthL <= WIDTH_BYTE;
         signL  <= 1'b0;
         addrL  <= '0;
         dataL  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  rdL    <= Mem_DcacheRd;
                  widthL <= Mem_DcacheWidth;
                  signL  <= Mem_DcacheSign;
                  addrL  <= Mem_DcacheAddr[AW+1:0];
                  dataL  <= EXMem_Rs2Data;
                  cnt    <= CNT_INIT;
                  state  <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 1'b1;
               // Leaving when the count reaches zero keeps WAIT exactly WAIT_CYCLES long.
               if (cnt == CNT_W'(1)) state <= ST_RESP;
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      memBe     = 4'b0000;
      memWrData = dataL;
      case (widthL)
         WIDTH_BYTE: begin
            memBe     = 4'b0001 << addrL[1:0];
            memWrData = {4{dataL[7:0]}};
         end
         WIDTH_HALF: begin
            memBe     = addrL[1] ? 4'b1100 : 4'b0011;
            memWrData = {2{dataL[15:0]}};
         end
         WIDTH_WORD: begin
            memBe     = 4'b1111;
            memWrData = dataL;
         end
         default: begin
            memBe     = 4'b0000;
            memWrData = dataL;
         end
      endcase
   end

   // Store lands on the edge that ends RESP, so a read during RESP sees old data.
   assign memWe = (state == ST_RESP) && !rdL;

   dmem_sram #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_sram (
      .clk   (clk),
      .we    (memWe),
      .be    (memBe),
      .idx   (addrL[AW+1:2]),
      .wrData(memWrData),
      .rdData(rdWord)
   );

   always_comb begin
      logic [7:0]  byteLane;
      logic [15:0] halfLane;
      byteLane = rdWord[{addrL[1:0], 3'b000} +: 8];
      halfLane = rdWord[{addrL[1], 4'b0000} +: 16];
      loadData = '0;
      if ((state == ST_RESP) && rdL) begin
         case (widthL)
            WIDTH_BYTE: loadData = {{24{signL & byteLane[7]}}, byteLane};
            WIDTH_HALF: loadData = {{16{signL & halfLane[15]}}, halfLane};
            default:    loadData = rdWord;
         endcase
      end
   end

   assign Dcache_DataRd = loadData;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a WAIT_CYCLES=2 instance for most
// scenarios and a WAIT_CYCLES=0 instance for back-to-back timing.
module tb_data_mem_responder;
   import data_mem_responder_pkg::*;

   localparam int DEPTH = 1024;
   localparam int WAITC = 2;

   logic        clk = 1'b0;
   logic        rst;

   logic        en, rd, sign;
   logic [1:0]  width;
   logic [31:0] addr, wdata;
   logic [31:0] dataRd;
   logic        stall, done, mis;

   logic        en0, rd0, sign0;
   logic [1:0]  width0;
   logic [31:0] addr0, wdata0;
   logic [31:0] dataRd0;
   logic        stall0, done0, mis0;

   int total = 0;
   int bad   = 0;

   logic [31:0] memModel [int];
   logic [31:0] expQ [$];
   logic [31:0] expQ0 [$];

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
      .clk(clk), .rst(rst),
      .Mem_DcacheEN(en), .Mem_DcacheRd(rd), .Mem_DcacheWidth(width),
      .Mem_DcacheSign(sign), .Mem_DcacheAddr(addr), .EXMem_Rs2Data(wdata),
      .Dcache_DataRd(dataRd), .Dcache_StallReq(stall), .Dcache_Done(done),
      .Dcache_Misalign(mis)
   );

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst),
      .Mem_DcacheEN(en0), .Mem_DcacheRd(rd0), .Mem_DcacheWidth(width0),
      .Mem_DcacheSign(sign0), .Mem_DcacheAddr(addr0), .EXMem_Rs2Data(wdata0),
      .Dcache_DataRd(dataRd0), .Dcache_StallReq(stall0), .Dcache_Done(done0),
      .Dcache_Misalign(mis0)
   );

   function automatic logic [31:0] expLoad(input logic [31:0] w, input logic [1:0] wd,
                                           input logic s, input logic [1:0] off);
      logic [31:0] sh;
      sh = w >> {off, 3'b000};
      case (wd)
         2'b00:   return s ? 32'($signed(sh[7:0]))  : 32'(sh[7:0]);
         2'b01:   return s ? 32'($signed(sh[15:0])) : 32'(sh[15:0]);
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] mergeStore(input logic [31:0] old, input logic [1:0] wd,
                                              input logic [1:0] off, input logic [31:0] d);
      logic [31:0] mask, val;
      case (wd)
         2'b00: begin
            mask = 32'h0000_00FF << {off, 3'b000};
            val  = (d & 32'h0000_00FF) << {off, 3'b000};
         end
         2'b01: begin
            mask = 32'h0000_FFFF << {off, 3'b000};
            val  = (d & 32'h0000_FFFF) << {off, 3'b000};
         end
         default: begin
            mask = 32'hFFFF_FFFF;
            val  = d;
         end
      endcase
      return (old & ~mask) | (val & mask);
   endfunction

   // One complete access on the main instance; call just after a rising edge.
   task automatic access(input logic r, input logic [1:0] w, input logic s,
                         input logic [31:0] a, input logic [31:0] d, input string name);
      int stallCnt = 0;
      int doneCyc  = -1;
      int idx;
      logic [31:0] exp;
      idx = int'((a >> 2) % DEPTH);
      if (r) expQ.push_back(expLoad(memModel[idx], w, s, a[1:0]));
      else   memModel[idx] = mergeStore(memModel[idx], w, a[1:0], d);
      en = 1'b1; rd = r; width = w; sign = s; addr = a; wdata = d;
      for (int k = 0; k < WAITC + 10; k++) begin
         @(negedge clk);
         if (stall) stallCnt++;
         if (done) begin
            doneCyc = k;
            break;
         end
         total++;
         if (dataRd !== 32'h0) begin
            bad++;
            $display("FAIL %s data_when_not_done got=%h want=00000000", name, dataRd);
         end
         @(posedge clk); #1;
      end
      total++;
      if (doneCyc != WAITC + 1) begin
         bad++;
         $display("FAIL %s done_cycle got=%0d want=%0d", name, doneCyc, WAITC + 1);
      end
      total++;
      if (stallCnt != WAITC + 1) begin
         bad++;
         $display("FAIL %s stall_cycles got=%0d want=%0d", name, stallCnt, WAITC + 1);
      end
      if (r) begin
         exp = expQ.pop_front();
         total++;
         if (dataRd !== exp) begin
            bad++;
            $display("FAIL %s load_data got=%h want=%h", name, dataRd, exp);
         end
      end
      @(posedge clk); #1;
      en = 1'b0;
   endtask

   task automatic test_reset();
      en = 1'b1; rd = 1'b1; width = WIDTH_WORD; sign = 1'b0; addr = 32'h0; wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++;
      if (dataRd !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=00000000", dataRd); end
      total++;
      if (done0 !== 1'b0 || stall0 !== 1'b0) begin
         bad++;
         $display("FAIL reset_dut0 got done=%b stall=%b want 0 0", done0, stall0);
      end
      @(posedge clk); #1;
      en = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_store_load();
      access(1'b0, WIDTH_WORD, 1'b0, 32'h100, 32'hDEADBEEF, "sw_100");
      access(1'b1, WIDTH_WORD, 1'b0, 32'h100, 32'h0, "lw_100");
   endtask

   task automatic test_extension();
      access(1'b0, WIDTH_WORD, 1'b0, 32'h200, 32'h0000_80F0, "sw_200");
      access(1'b1, WIDTH_BYTE, 1'b1, 32'h200, 32'h0, "lb_200");
      access(1'b1, WIDTH_BYTE, 1'b0, 32'h200, 32'h0, "lbu_200");
      access(1'b1, WIDTH_HALF, 1'b1, 32'h200, 32'h0, "lh_200");
      access(1'b1, WIDTH_BYTE, 1'b1, 32'h201, 32'h0, "lb_201");
      access(1'b1, WIDTH_HALF, 1'b0, 32'h200, 32'h0, "lhu_200");
   endtask

   task automatic test_half_store();
      access(1'b0, WIDTH_WORD, 1'b0, 32'h300, 32'hAAAAAAAA, "sw_300");
      access(1'b0, WIDTH_HALF, 1'b0, 32'h302, 32'h0000_1234, "sh_302");
      access(1'b1, WIDTH_WORD, 1'b0, 32'h300, 32'h0, "lw_300");
      total++;
      if (memModel[int'(32'h300 >> 2)] !== 32'h1234AAAA) begin
         bad++;
         $display("FAIL model_300 got=%h want=1234aaaa", memModel[int'(32'h300 >> 2)]);
      end
   endtask

   task automatic test_misalign();
      logic        rs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      logic [1:0]  ws [4] = '{WIDTH_WORD, WIDTH_HALF, 2'b11, WIDTH_WORD};
      logic [31:0] as [4] = '{32'h101, 32'h103, 32'h100, 32'h102};
      for (int i = 0; i < 4; i++) begin
         logic sawActivity = 1'b0;
         en = 1'b1; rd = rs[i]; width = ws[i]; sign = 1'b0; addr = as[i]; wdata = 32'h0BADF00D;
         @(negedge clk);
         total++;
         if (mis !== 1'b1 || stall !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL misalign_%0d got mis=%b stall=%b done=%b want 1 0 0", i, mis, stall, done);
         end
         @(posedge clk); #1;
         en = 1'b0;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || stall) sawActivity = 1'b1;
         end
         total++;
         if (sawActivity !== 1'b0) begin
            bad++;
            $display("FAIL misalign_quiet_%0d got activity=%b want=0", i, sawActivity);
         end
         @(posedge clk); #1;
      end
      access(1'b1, WIDTH_WORD, 1'b0, 32'h100, 32'h0, "lw_100_unchanged");
   endtask

   task automatic test_back_to_back();
      logic        rs [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic [31:0] as [4] = '{32'h0, 32'h4, 32'h0, 32'h4};
      logic [31:0] ds [4] = '{32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0};
      logic [31:0] exp;
      int op = 0;
      en0 = 1'b1; rd0 = rs[0]; width0 = WIDTH_WORD; sign0 = 1'b0; addr0 = as[0]; wdata0 = ds[0];
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk);
         total++;
         if (stall0 !== (cyc % 2 == 0)) begin
            bad++;
            $display("FAIL b2b_stall cyc=%0d got=%b want=%b", cyc, stall0, (cyc % 2 == 0));
         end
         total++;
         if (done0 !== (cyc % 2 == 1)) begin
            bad++;
            $display("FAIL b2b_done cyc=%0d got=%b want=%b", cyc, done0, (cyc % 2 == 1));
         end
         if (cyc % 2 == 1 && rs[op]) begin
            exp = expQ0.pop_front();
            total++;
            if (dataRd0 !== exp) begin
               bad++;
               $display("FAIL b2b_load cyc=%0d got=%h want=%h", cyc, dataRd0, exp);
            end
         end
         @(posedge clk); #1;
         if (cyc % 2 == 1 && cyc < 7) begin
            op = (cyc + 1) / 2;
            rd0 = rs[op]; addr0 = as[op]; wdata0 = ds[op];
            if (rs[op]) expQ0.push_back(op == 2 ? 32'h1111_1111 : 32'h2222_2222);
         end
      end
      en0 = 1'b0;
   endtask

   task automatic test_reset_abort();
      access(1'b0, WIDTH_WORD, 1'b0, 32'h10, 32'hA0B0_C0D0, "sw_10");
      en = 1'b1; rd = 1'b0; width = WIDTH_BYTE; sign = 1'b0; addr = 32'h10; wdata = 32'h55;
      @(negedge clk);
      total++;
      if (stall !== 1'b1) begin bad++; $display("FAIL abort_accept_stall got=%b want=1", stall); end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      total++;
      if (stall !== 1'b0 || done !== 1'b0 || dataRd !== 32'h0) begin
         bad++;
         $display("FAIL abort_outputs got stall=%b done=%b data=%h want 0 0 0", stall, done, dataRd);
      end
      @(posedge clk); #1;
      en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      access(1'b1, WIDTH_WORD, 1'b0, 32'h10, 32'h0, "lw_10_after_abort");
      access(1'b1, WIDTH_WORD, 1'b0, 32'h10 + DEPTH * 4, 32'h0, "lw_10_alias");
      access(1'b0, WIDTH_BYTE, 1'b0, 32'h11 + DEPTH * 4, 32'h77, "sb_11_alias");
      access(1'b1, WIDTH_BYTE, 1'b0, 32'h11, 32'h0, "lbu_11");
      access(1'b1, WIDTH_WORD, 1'b0, 32'h10, 32'h0, "lw_10_final");
   endtask

   initial begin
      rst = 1'b1;
      en = 1'b0; rd = 1'b0; width = 2'b00; sign = 1'b0; addr = 32'h0; wdata = 32'h0;
      en0 = 1'b0; rd0 = 1'b0; width0 = 2'b00; sign0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
      test_reset();
      test_store_load();
      test_extension();
      test_half_store();
      test_misalign();
      test_back_to_back();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
